// File: rtl/pwm_deadtime_leg_if.sv
// Gate-drive bundle for one PWM half-bridge leg: the duty command goes in, and the gate
// enables and the valley sync come out.
interface pwm_deadtime_leg_if;
  logic               en;
  logic signed [15:0] d;
  logic               dv;
  logic               hi;
  logic               lo;
  logic               sync;

  modport master (output en, d, dv, input  hi, lo, sync);
  modport slave  (input  en, d, dv, output hi, lo, sync);
endinterface

// File: rtl/pwm_deadtime_leg.sv
// Center-aligned PWM for one half-bridge leg with a double-buffered duty command,
// complementary gate enables separated by a fixed deadtime, and a valley sync pulse.
module pwm_deadtime_leg #(
  parameter int unsigned PERIOD = 1000,
  parameter int unsigned DEAD   = 20
) (
  input  logic              c,
  input  logic              rst_n,
  pwm_deadtime_leg_if.slave bus
);

  localparam int CW = 14;
  localparam logic [CW-1:0]      PER     = CW'(PERIOD);
  localparam logic [CW-1:0]      HALF    = CW'(PERIOD / 2);
  localparam logic signed [17:0] PER_S   = 18'(PERIOD);
  localparam logic signed [17:0] HALF_S  = 18'(PERIOD / 2);
  localparam logic [7:0]         DT_INIT = 8'(DEAD);

  typedef enum logic [1:0] {ST_OFF, ST_HI, ST_LO, ST_DT} state_e;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               up_q, up_d;
  logic [CW-1:0]      shadow_q, shadow_d;
  logic [CW-1:0]      active_q, active_d;
  state_e             state_q, state_d;
  logic [7:0]         dt_q, dt_d;
  logic               hi_q, lo_q, sync_q;
  logic               raw, valley;
  logic signed [17:0] d_ext, cmp_sum;
  logic [CW-1:0]      cmp_new;

  assign valley = (cnt_q == '0);
  assign raw    = (cnt_q < active_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    up_d  = up_q;
    if (up_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == PER - 1'b1) up_d = 1'b0;
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) up_d = 1'b1;
    end
  end

  // The 18-bit sum cannot overflow for any 16-bit command, so clamping it is exact.
  assign d_ext   = 18'(bus.d);
  assign cmp_sum = HALF_S + d_ext;

  always_comb begin
    if (cmp_sum[17])         cmp_new = '0;
    else if (cmp_sum > PER_S) cmp_new = PER;
    else                      cmp_new = cmp_sum[CW-1:0];
  end

  // Active takes the pre-edge shadow at the valley, so a same-clock strobe waits a period.
  always_comb begin
    shadow_d = bus.dv ? cmp_new : shadow_q;
    active_d = valley ? shadow_q : active_q;
  end

  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    unique case (state_q)
      ST_OFF: begin
        state_d = ST_DT;
        dt_d    = DT_INIT;
      end
      ST_HI: if (!raw) begin
        state_d = ST_DT;
        dt_d    = DT_INIT;
      end
      ST_LO: if (raw) begin
        state_d = ST_DT;
        dt_d    = DT_INIT;
      end
      ST_DT: begin
        dt_d = dt_q - 1'b1;
        if (dt_q == 8'd1) state_d = raw ? ST_HI : ST_LO;
      end
      default: state_d = ST_OFF;
    endcase
    if (!bus.en) state_d = ST_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      up_q     <= 1'b1;
      shadow_q <= HALF;
      active_q <= HALF;
      state_q  <= ST_OFF;
      dt_q     <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      state_q  <= state_d;
      dt_q     <= dt_d;
      hi_q     <= (state_d == ST_HI);
      lo_q     <= (state_d == ST_LO);
      sync_q   <= valley;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.sync = sync_q;

endmodule
